// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the multi-cycle data memory responder and the MEM stage.
package data_mem_responder_pkg;

  // Default data-path geometry, shared with the MEM stage.
  localparam int DM_DATA_W      = 8;
  localparam int DM_ADDR_W      = 8;

  // Wait-cycle counter: LATENCY must fit into it.
  localparam int DM_LATENCY_MAX = 15;
  localparam int DM_CNT_W       = 4;

  // Responder control states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dm_state_e;

endpackage

// File: rtl/data_mem_responder_dm_array.sv
// Byte-addressed storage array: synchronous write, synchronous read into a register.
module dm_array
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_W = DM_DATA_W,
  parameter int ADDR_W = DM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Array write on the access edge.
  // NOTE: the storage has no reset on purpose; contents must survive a reset
  // of the control logic, and a reset loop over every word would not map to RAM.
  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Read data register; only a read access updates it, so it holds otherwise.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_en && !i_we) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: one outstanding request, access after LATENCY wait
// cycles, result returned over a valid/ready response channel.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_W  = DM_DATA_W,
  parameter int ADDR_W  = DM_ADDR_W,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
);

  // Reject latencies the wait counter cannot represent.
  if (LATENCY < 0 || LATENCY > DM_LATENCY_MAX) begin : g_latency_check
    $error("data_mem_responder: LATENCY %0d outside 0..%0d", LATENCY, DM_LATENCY_MAX);
  end

  localparam logic [DM_CNT_W-1:0] LAT_LOAD = DM_CNT_W'(LATENCY);
  // With zero latency the acceptance edge is the access edge, so the array
  // is fed straight from the request bus instead of the latched copy.
  localparam bit ZERO_LAT = (LATENCY == 0);

  dm_state_e           r_state;
  dm_state_e           w_state_nxt;
  logic [DM_CNT_W-1:0] r_cnt;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_rsp_write;

  logic                w_accept;
  logic                w_access;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;
  logic [DATA_W-1:0]   w_arr_rdata;

  // Next-state logic plus the acceptance and access strobes.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (ZERO_LAT) begin
            w_access    = 1'b1;
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (r_cnt == DM_CNT_W'(1)) begin
          w_access    = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request capture at acceptance and wait-cycle countdown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_cnt   <= LAT_LOAD;
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end else if (r_state == WAIT) begin
      r_cnt   <= r_cnt - 1'b1;
    end
  end

  // Response write flag, captured on the access edge and held through RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_write <= 1'b0;
    end else if (w_access) begin
      r_rsp_write <= w_mem_we;
    end
  end

  assign w_mem_we    = ZERO_LAT ? req_write : r_write;
  assign w_mem_addr  = ZERO_LAT ? req_addr  : r_addr;
  assign w_mem_wdata = ZERO_LAT ? req_wdata : r_wdata;

  dm_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_dm_array (
    .clk     (clk),
    .rst_n   (reset),
    .i_en    (w_access),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_addr),
    .i_wdata (w_mem_wdata),
    .o_rdata (w_arr_rdata)
  );

  // The read register only moves on reads, so write responses force zero here.
  assign rsp_rdata = r_rsp_write ? '0 : w_arr_rdata;
  assign rsp_write = r_rsp_write;
  assign rsp_valid = (r_state == RESP);
  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at LATENCY 2, 0 and 3.
module tb_data_mem_responder;

  logic       clk;
  logic       rst_n     [3];
  logic       req_valid [3];
  logic       req_ready [3];
  logic       req_write [3];
  logic [7:0] req_addr  [3];
  logic [7:0] req_wdata [3];
  logic       rsp_valid [3];
  logic       rsp_ready [3];
  logic       rsp_write [3];
  logic [7:0] rsp_rdata [3];
  logic       busy      [3];

  int n_cmp = 0;
  int n_bad = 0;

  data_mem_responder #(.DATA_W(8), .ADDR_W(8), .LATENCY(2)) u_dut0 (
    .clk(clk), .reset(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_write(rsp_write[0]),
    .rsp_rdata(rsp_rdata[0]), .busy(busy[0])
  );

  data_mem_responder #(.DATA_W(8), .ADDR_W(8), .LATENCY(0)) u_dut1 (
    .clk(clk), .reset(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_write(rsp_write[1]),
    .rsp_rdata(rsp_rdata[1]), .busy(busy[1])
  );

  data_mem_responder #(.DATA_W(8), .ADDR_W(8), .LATENCY(3)) u_dut2 (
    .clk(clk), .reset(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_write(rsp_write[2]),
    .rsp_rdata(rsp_rdata[2]), .busy(busy[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with rsp_ready high; lat = edges from acceptance
  // (inclusive) until rsp_valid is first seen.
  task automatic xact(input int d, input logic we, input logic [7:0] addr,
                      input logic [7:0] wdata, output logic [7:0] rdata,
                      output logic rwr, output int lat);
    bit acc = 1'b0;
    int n;
    rdata = 8'hxx;
    rwr   = 1'bx;
    lat   = -1;
    req_write[d] = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_valid[d] = 1'b1;
    rsp_ready[d] = 1'b1;
    for (int k = 0; k < 40 && !acc; k++) begin
      if (req_ready[d] === 1'b1) acc = 1'b1;
      step();
    end
    req_valid[d] = 1'b0;
    n = 1;
    while (rsp_valid[d] !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    n_cmp++;
    if (!acc || rsp_valid[d] !== 1'b1) begin
      n_bad++;
      $display("FAIL xact_timeout dut%0d addr=%h accepted=%0d rsp_valid=%b", d, addr, acc, rsp_valid[d]);
    end else begin
      lat   = n;
      rdata = rsp_rdata[d];
      rwr   = rsp_write[d];
      step();
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_write[d] = 1'b0;
      req_addr[d] = 8'h00; req_wdata[d] = 8'h00; rsp_ready[d] = 1'b0;
    end
    step();
    step();
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if ({req_ready[d], rsp_valid[d], rsp_write[d], busy[d]} !== 4'b1000) begin
        n_bad++;
        $display("FAIL reset_ctrl dut%0d got %b want 1000", d,
                 {req_ready[d], rsp_valid[d], rsp_write[d], busy[d]});
      end
      n_cmp++;
      if (rsp_rdata[d] !== 8'h00) begin
        n_bad++;
        $display("FAIL reset_rdata dut%0d got %h want 00", d, rsp_rdata[d]);
      end
    end
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
    step();
  endtask

  task automatic test_write_lat2();
    logic [7:0] rd;
    logic       rw;
    int         lat;
    req_write[0] = 1'b1; req_addr[0] = 8'h10; req_wdata[0] = 8'hA5;
    req_valid[0] = 1'b1; rsp_ready[0] = 1'b0;
    step();                                  // E0
    req_valid[0] = 1'b0;
    n_cmp++;
    if ({req_ready[0], busy[0], rsp_valid[0]} !== 3'b010) begin
      n_bad++;
      $display("FAIL wr_after_e0 got %b want 010", {req_ready[0], busy[0], rsp_valid[0]});
    end
    step();                                  // E0+1
    n_cmp++;
    if ({req_ready[0], busy[0], rsp_valid[0]} !== 3'b010) begin
      n_bad++;
      $display("FAIL wr_e0p1 got %b want 010", {req_ready[0], busy[0], rsp_valid[0]});
    end
    step();                                  // E0+2: access edge
    n_cmp++;
    if ({req_ready[0], busy[0], rsp_valid[0], rsp_write[0]} !== 4'b0111) begin
      n_bad++;
      $display("FAIL wr_rsp got %b want 0111", {req_ready[0], busy[0], rsp_valid[0], rsp_write[0]});
    end
    n_cmp++;
    if (rsp_rdata[0] !== 8'h00) begin
      n_bad++;
      $display("FAIL wr_rsp_rdata got %h want 00", rsp_rdata[0]);
    end
    rsp_ready[0] = 1'b1;
    step();                                  // handshake
    rsp_ready[0] = 1'b0;
    n_cmp++;
    if ({req_ready[0], busy[0], rsp_valid[0]} !== 3'b100) begin
      n_bad++;
      $display("FAIL wr_done got %b want 100", {req_ready[0], busy[0], rsp_valid[0]});
    end
    xact(0, 1'b0, 8'h10, 8'h00, rd, rw, lat);
    n_cmp++;
    if ({rw, rd} !== {1'b0, 8'hA5} || lat != 3) begin
      n_bad++;
      $display("FAIL rd_10_lat2 got w=%b d=%h lat=%0d want w=0 d=a5 lat=3", rw, rd, lat);
    end
  endtask

  task automatic test_lat0();
    logic [7:0] rd;
    logic       rw;
    int         lat;
    xact(1, 1'b1, 8'h10, 8'hA5, rd, rw, lat);
    n_cmp++;
    if ({rw, rd} !== {1'b1, 8'h00} || lat != 1) begin
      n_bad++;
      $display("FAIL lat0_wr got w=%b d=%h lat=%0d want w=1 d=00 lat=1", rw, rd, lat);
    end
    req_write[1] = 1'b0; req_addr[1] = 8'h10; req_valid[1] = 1'b1; rsp_ready[1] = 1'b1;
    step();                                  // E0
    n_cmp++;
    if ({rsp_valid[1], req_ready[1], rsp_write[1]} !== 3'b100 || rsp_rdata[1] !== 8'hA5) begin
      n_bad++;
      $display("FAIL lat0_rd got v=%b r=%b w=%b d=%h want v=1 r=0 w=0 d=a5",
               rsp_valid[1], req_ready[1], rsp_write[1], rsp_rdata[1]);
    end
    step();                                  // E0+1: handshake
    n_cmp++;
    if ({rsp_valid[1], req_ready[1]} !== 2'b01) begin
      n_bad++;
      $display("FAIL lat0_e0p1 got %b want 01", {rsp_valid[1], req_ready[1]});
    end
    step();                                  // E0+2: next request accepted
    req_valid[1] = 1'b0;
    n_cmp++;
    if ({rsp_valid[1], rsp_rdata[1]} !== {1'b1, 8'hA5}) begin
      n_bad++;
      $display("FAIL lat0_next got v=%b d=%h want v=1 d=a5", rsp_valid[1], rsp_rdata[1]);
    end
    step();
    n_cmp++;
    if ({rsp_valid[1], req_ready[1], busy[1]} !== 3'b010) begin
      n_bad++;
      $display("FAIL lat0_idle got %b want 010", {rsp_valid[1], req_ready[1], busy[1]});
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] rd;
    logic       rw;
    int         lat;
    req_write[0] = 1'b0; req_addr[0] = 8'h10; req_valid[0] = 1'b1; rsp_ready[0] = 1'b0;
    step();                                  // E0: read accepted
    req_write[0] = 1'b1; req_addr[0] = 8'h11; req_wdata[0] = 8'h5A;
    step();
    step();                                  // access edge
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({rsp_valid[0], req_ready[0], rsp_write[0]} !== 3'b100 || rsp_rdata[0] !== 8'hA5) begin
        n_bad++;
        $display("FAIL bp_hold cyc%0d got v=%b r=%b w=%b d=%h want v=1 r=0 w=0 d=a5", i,
                 rsp_valid[0], req_ready[0], rsp_write[0], rsp_rdata[0]);
      end
      if (i < 4) step();
    end
    rsp_ready[0] = 1'b1;
    step();                                  // handshake
    rsp_ready[0] = 1'b0;
    n_cmp++;
    if ({rsp_valid[0], req_ready[0], busy[0]} !== 3'b010) begin
      n_bad++;
      $display("FAIL bp_release got %b want 010", {rsp_valid[0], req_ready[0], busy[0]});
    end
    step();                                  // pending write accepted
    req_valid[0] = 1'b0;
    n_cmp++;
    if ({req_ready[0], busy[0]} !== 2'b01) begin
      n_bad++;
      $display("FAIL bp_wr_accept got %b want 01", {req_ready[0], busy[0]});
    end
    step();
    step();
    n_cmp++;
    if ({rsp_valid[0], rsp_write[0], rsp_rdata[0]} !== {2'b11, 8'h00}) begin
      n_bad++;
      $display("FAIL bp_wr_rsp got v=%b w=%b d=%h want v=1 w=1 d=00",
               rsp_valid[0], rsp_write[0], rsp_rdata[0]);
    end
    rsp_ready[0] = 1'b1;
    step();
    xact(0, 1'b0, 8'h11, 8'h00, rd, rw, lat);
    n_cmp++;
    if ({rw, rd} !== {1'b0, 8'h5A}) begin
      n_bad++;
      $display("FAIL bp_rd_11 got w=%b d=%h want w=0 d=5a", rw, rd);
    end
    xact(0, 1'b0, 8'h10, 8'h00, rd, rw, lat);
    n_cmp++;
    if (rd !== 8'hA5) begin
      n_bad++;
      $display("FAIL bp_rd_10 got %h want a5", rd);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [7:0] rd;
    logic       rw;
    int         lat;
    xact(2, 1'b1, 8'h20, 8'h11, rd, rw, lat);
    n_cmp++;
    if (lat != 4 || rw !== 1'b1) begin
      n_bad++;
      $display("FAIL lat3_wr got lat=%0d w=%b want lat=4 w=1", lat, rw);
    end
    req_write[2] = 1'b1; req_addr[2] = 8'h20; req_wdata[2] = 8'hFF;
    req_valid[2] = 1'b1; rsp_ready[2] = 1'b1;
    step();                                  // E0
    req_valid[2] = 1'b0;
    n_cmp++;
    if ({req_ready[2], busy[2]} !== 2'b01) begin
      n_bad++;
      $display("FAIL rst_wait_busy got %b want 01", {req_ready[2], busy[2]});
    end
    step();                                  // E0+1, still waiting
    #2;
    rst_n[2] = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready[2], rsp_valid[2], rsp_write[2], busy[2], rsp_rdata[2]} !== {4'b1000, 8'h00}) begin
      n_bad++;
      $display("FAIL rst_async got r=%b v=%b w=%b b=%b d=%h want r=1 v=0 w=0 b=0 d=00",
               req_ready[2], rsp_valid[2], rsp_write[2], busy[2], rsp_rdata[2]);
    end
    step();
    rst_n[2] = 1'b1;
    step();
    step();
    step();
    n_cmp++;
    if ({req_ready[2], busy[2], rsp_valid[2]} !== 3'b100) begin
      n_bad++;
      $display("FAIL rst_release got %b want 100", {req_ready[2], busy[2], rsp_valid[2]});
    end
    xact(2, 1'b0, 8'h20, 8'h00, rd, rw, lat);
    n_cmp++;
    if ({rw, rd} !== {1'b0, 8'h11}) begin
      n_bad++;
      $display("FAIL rst_rd_20 got w=%b d=%h want w=0 d=11", rw, rd);
    end
  endtask

  task automatic test_boundary();
    logic [7:0] rd;
    logic       rw;
    int         lat;
    xact(0, 1'b1, 8'h00, 8'h3C, rd, rw, lat);
    xact(0, 1'b1, 8'hFF, 8'hC3, rd, rw, lat);
    xact(0, 1'b0, 8'h00, 8'h00, rd, rw, lat);
    n_cmp++;
    if ({rw, rd} !== {1'b0, 8'h3C} || lat != 3) begin
      n_bad++;
      $display("FAIL bnd_rd_00 got w=%b d=%h lat=%0d want w=0 d=3c lat=3", rw, rd, lat);
    end
    xact(0, 1'b0, 8'hFF, 8'h00, rd, rw, lat);
    n_cmp++;
    if ({rw, rd} !== {1'b0, 8'hC3} || lat != 3) begin
      n_bad++;
      $display("FAIL bnd_rd_ff got w=%b d=%h lat=%0d want w=0 d=c3 lat=3", rw, rd, lat);
    end
  endtask

  initial begin
    test_reset();
    test_write_lat2();
    test_lat0();
    test_backpressure();
    test_reset_mid_wait();
    test_boundary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
